// File: rtl/csa_accum_ctrl_if.sv
// Stream and control bundle for the carry-save accumulator sequencer.
// master: operand source / result consumer side; slave: the sequencer.
interface csa_accum_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16,
    parameter int CNT_W = 5
);
    logic             start;
    logic [CNT_W-1:0] op_count;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             busy;

    modport master (
        output start, op_count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  start, op_count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: folds a burst of operands into redundant
// sum/carry registers with one 3:2 CSA step per accepted operand, then
// resolves the pair with a single carry-propagate add.
module csa_accum_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ACC_W   = 16,
    parameter int MAX_OPS = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    csa_accum_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RESOLVE, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] sum_reg, sum_next;
    logic [ACC_W-1:0] car_reg, car_next;
    logic [ACC_W-1:0] out_sum_reg, out_sum_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] target_reg, target_next;
    logic             out_valid_reg, out_valid_next;

    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] csa_sum;
    logic [ACC_W-1:0] csa_maj;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] target_clamped;

    assign x              = ACC_W'(bus.in_data);
    assign cnt_inc        = cnt_reg + CNT_W'(1);
    assign target_clamped = (bus.op_count > MAX_CNT) ? MAX_CNT : bus.op_count;

    // Bitwise 3:2 compressor: full-adder sum and majority per bit position
    genvar gi;
    generate
        for (gi = 0; gi < ACC_W; gi++) begin : g_csa
            assign csa_sum[gi] = sum_reg[gi] ^ car_reg[gi] ^ x[gi];
            assign csa_maj[gi] = (sum_reg[gi] & car_reg[gi]) |
                                 (sum_reg[gi] & x[gi]) |
                                 (car_reg[gi] & x[gi]);
        end
    endgenerate

    // Next-state and datapath updates; every register holds by default
    always_comb begin
        state_next     = state_reg;
        sum_next       = sum_reg;
        car_next       = car_reg;
        out_sum_next   = out_sum_reg;
        cnt_next       = cnt_reg;
        target_next    = target_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    sum_next    = '0;
                    car_next    = '0;
                    cnt_next    = '0;
                    target_next = target_clamped;
                    state_next  = (bus.op_count == '0) ? RESOLVE : LOAD;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    sum_next = csa_sum;
                    // Carry weight moves up one bit; the top majority bit is
                    // beyond the accumulator and is dropped.
                    car_next = csa_maj << 1;
                    cnt_next = cnt_inc;
                    if (cnt_inc == target_reg) begin
                        state_next = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_sum_next   = sum_reg + car_reg;
                out_valid_next = 1'b1;
                state_next     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sum_reg       <= '0;
            car_reg       <= '0;
            out_sum_reg   <= '0;
            cnt_reg       <= '0;
            target_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sum_reg       <= sum_next;
            car_reg       <= car_next;
            out_sum_reg   <= out_sum_next;
            cnt_reg       <= cnt_next;
            target_reg    <= target_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.in_ready  = (state_reg == LOAD);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = out_sum_reg;
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: bursts with hand-computed totals,
// latency, backpressure, reset mid-burst, start filtering and clamping.
module tb_csa_accum_ctrl;
    localparam int WIDTH   = 8;
    localparam int ACC_W   = 16;
    localparam int MAX_OPS = 16;
    localparam int CNT_W   = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   accepts  = 0;

    csa_accum_ctrl_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    csa_accum_ctrl #(
        .WIDTH(WIDTH), .ACC_W(ACC_W), .MAX_OPS(MAX_OPS), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count a handshake seen before the edge, then move 1 time unit past it
    task automatic tick();
        if (bus.in_valid && bus.in_ready) accepts++;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_burst(input logic [CNT_W-1:0] n);
        accepts      = 0;
        bus.start    = 1'b1;
        bus.op_count = n;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op_count  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: three operands back-to-back
        begin_burst(5'd3);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h55; tick();
        bus.in_data = 8'hAA; tick();
        bus.in_data = 8'hC4; tick();
        bus.in_valid = 1'b0;
        check("t1_accepts", 32'(accepts), 32'd3);
        check("t1_ov_early", 32'(bus.out_valid), 32'd0);
        check("t1_rdy_resolve", 32'(bus.in_ready), 32'd0);
        tick();
        check("t1_ov", 32'(bus.out_valid), 32'd1);
        check("t1_sum", 32'(bus.out_sum), 32'h1C3);
        handshake("t1");

        // 2: sixteen 0xFF operands, largest total
        begin_burst(5'd16);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < 16; i++) tick();
        bus.in_valid = 1'b0;
        check("t2_accepts", 32'(accepts), 32'd16);
        check("t2_ov_early", 32'(bus.out_valid), 32'd0);
        tick();
        check("t2_ov", 32'(bus.out_valid), 32'd1);
        check("t2_sum", 32'(bus.out_sum), 32'h0FF0);
        handshake("t2");

        // 3: empty burst, in_valid offered but never taken
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        begin_burst(5'd0);
        check("t3_in_ready", 32'(bus.in_ready), 32'd0);
        check("t3_busy", 32'(bus.busy), 32'd1);
        check("t3_ov_early", 32'(bus.out_valid), 32'd0);
        tick();
        check("t3_ov", 32'(bus.out_valid), 32'd1);
        check("t3_sum", 32'(bus.out_sum), 32'd0);
        bus.in_valid = 1'b0;
        check("t3_accepts", 32'(accepts), 32'd0);
        handshake("t3");

        // 4: gappy input and consumer backpressure
        begin_burst(5'd4);
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            tick();
            bus.in_valid = 1'b0;
            bus.in_data  = 8'hEE;
            if (i == 4) check("t4_ov_early", 32'(bus.out_valid), 32'd0);
            tick();
        end
        check("t4_accepts", 32'(accepts), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("t4_ov_hold", 32'(bus.out_valid), 32'd1);
            check("t4_sum_hold", 32'(bus.out_sum), 32'h000A);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("t4_ov_clr", 32'(bus.out_valid), 32'd0);
        tick();
        bus.out_ready = 1'b0;
        check("t4_single_hs", 32'(bus.out_valid), 32'd0);
        check("t4_idle", 32'(bus.busy), 32'd0);

        // 5: reset mid-burst, then a fresh burst
        begin_burst(5'd4);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h11; tick();
        bus.in_data = 8'h22; tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_ready", 32'(bus.in_ready), 32'd0);
        check("t5_rst_ov", 32'(bus.out_valid), 32'd0);
        check("t5_rst_sum", 32'(bus.out_sum), 32'd0);
        begin_burst(5'd2);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h10; tick();
        bus.in_data = 8'h20; tick();
        bus.in_valid = 1'b0;
        tick();
        check("t5_ov", 32'(bus.out_valid), 32'd1);
        check("t5_sum", 32'(bus.out_sum), 32'h0030);
        handshake("t5");

        // 6: oversize count clamps; start held high is ignored outside IDLE
        begin_burst(5'd31);
        bus.start    = 1'b1;
        bus.op_count = 5'd2;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.in_data = 8'(i);
            tick();
        end
        bus.in_data = 8'h77;
        tick();
        bus.in_valid = 1'b0;
        check("t6_accepts", 32'(accepts), 32'd16);
        check("t6_ov", 32'(bus.out_valid), 32'd1);
        check("t6_sum", 32'(bus.out_sum), 32'h0088);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("t6_hs_idle", 32'(bus.busy), 32'd0);
        check("t6_hs_ov", 32'(bus.out_valid), 32'd0);
        tick();
        check("t6_stay_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
